// File: rtl/pwm_duty_ramp.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : pwm_duty_ramp
// Purpose  : Feeds the duty input of one PWM channel. A written target duty is
//            approached in increments of the written step size. One increment
//            is applied every DIV qualifying PWM wrap ticks, so brightness
//            fades rather than jumps. Duty changes only right after a wrap
//            tick, apart from the period clamp. A period clamp keeps the
//            output within the current PWM period.
// Ports    : CLK       - system clock
//            RST       - synchronous active-high reset
//            en        - ramp enable (low freezes ramp state and prescaler)
//            wr        - one-cycle strobe latching wr_target / wr_step
//            wr_target - new target duty
//            wr_step   - increment per update (0 = jump straight to target)
//            period    - current PWM period, clamps the duty output
//            tick      - one-cycle pulse at PWM counter wrap
//            duty      - registered, clamped duty output
//            busy      - high while the ramp has not reached its target
//            done      - one-cycle pulse when the target is reached
//            dir       - 1 = ramping up, 0 = ramping down or idle
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
module pwm_duty_ramp #(
    parameter int WIDTH = 28,
    parameter int DIV   = 4
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             en,
    input  logic             wr,
    input  logic [WIDTH-1:0] wr_target,
    input  logic [WIDTH-1:0] wr_step,
    input  logic [WIDTH-1:0] period,
    input  logic             tick,
    output logic [WIDTH-1:0] duty,
    output logic             busy,
    output logic             done,
    output logic             dir
);

    // Prescaler counter width; a DIV of 1 still needs a 1-bit counter.
    localparam int                 c_CNT_W    = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [c_CNT_W-1:0] c_LAST_CNT = c_CNT_W'(DIV - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_UP   = 2'd1,
        ST_DOWN = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   cur_q, cur_d;
    logic [WIDTH-1:0]   target_q, target_d;
    logic [WIDTH-1:0]   step_q, step_d;
    logic [c_CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0]   duty_q, duty_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               dir_q, dir_d;

    logic               w_qual_tick;
    logic [WIDTH:0]     w_sum;
    logic [WIDTH:0]     w_gap;
    logic [WIDTH-1:0]   w_step_cur;

    // A tick only counts while actively ramping; a tick that collides with a
    // write is dropped so the new target starts with a fresh prescale count.
    assign w_qual_tick = tick & en & ~wr & (state_q != ST_IDLE);

    // One extra bit so cur+step cannot wrap. w_gap is only meaningful in DOWN,
    // where cur > target is guaranteed.
    assign w_sum = {1'b0, cur_q} + {1'b0, step_q};
    assign w_gap = {1'b0, cur_q} - {1'b0, target_q};

    // Candidate cur value for one ramp update, saturating at the target.
    always_comb begin
        w_step_cur = cur_q;
        if (step_q == '0) begin
            w_step_cur = target_q;
        end else if (state_q == ST_UP) begin
            if (w_sum >= {1'b0, target_q}) begin
                w_step_cur = target_q;
            end else begin
                w_step_cur = w_sum[WIDTH-1:0];
            end
        end else if (state_q == ST_DOWN) begin
            if ({1'b0, step_q} >= w_gap) begin
                w_step_cur = target_q;
            end else begin
                w_step_cur = cur_q - step_q;
            end
        end
    end

    // Next-state logic for ramp state, prescaler and status flags.
    always_comb begin
        state_d  = state_q;
        cur_d    = cur_q;
        target_d = target_q;
        step_d   = step_q;
        cnt_d    = cnt_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        dir_d    = dir_q;

        if (wr) begin
            // Retarget from the present cur; cur itself is untouched.
            target_d = wr_target;
            step_d   = wr_step;
            cnt_d    = '0;
            if (wr_target > cur_q) begin
                state_d = ST_UP;
                busy_d  = 1'b1;
                dir_d   = 1'b1;
            end else if (wr_target < cur_q) begin
                state_d = ST_DOWN;
                busy_d  = 1'b1;
                dir_d   = 1'b0;
            end else begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
                dir_d   = 1'b0;
                done_d  = 1'b1;
            end
        end else if (w_qual_tick) begin
            if (cnt_q == c_LAST_CNT) begin
                cnt_d = '0;
                cur_d = w_step_cur;
                // Updates saturate at the target, so reaching it is the only
                // way the direction can change: no overshoot to handle.
                if (w_step_cur == target_q) begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                    dir_d   = 1'b0;
                    done_d  = 1'b1;
                end
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end

        // Clamp uses the next cur so the output lands in the same cycle as
        // the state/done change, and follows period even when idle.
        duty_d = (cur_d > period) ? period : cur_d;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q  <= ST_IDLE;
            cur_q    <= '0;
            target_q <= '0;
            step_q   <= '0;
            cnt_q    <= '0;
            duty_q   <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            dir_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cur_q    <= cur_d;
            target_q <= target_d;
            step_q   <= step_d;
            cnt_q    <= cnt_d;
            duty_q   <= duty_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            dir_q    <= dir_d;
        end
    end

    assign duty = duty_q;
    assign busy = busy_q;
    assign done = done_q;
    assign dir  = dir_q;

endmodule
`default_nettype wire

// File: tb/tb_pwm_duty_ramp.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : tb_pwm_duty_ramp
// Purpose  : Self-checking bench for pwm_duty_ramp. One instance with DIV=1
//            runs a table of per-cycle vectors; a second instance with DIV=4
//            runs hand-written prescale and enable sequences.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
module tb_pwm_duty_ramp;

    localparam int c_W = 28;

    logic           CLK;
    logic           RST;
    logic [c_W-1:0] wr_target;
    logic [c_W-1:0] wr_step;
    logic [c_W-1:0] period;

    logic           en1, wr1, tick1;
    logic [c_W-1:0] duty1;
    logic           busy1, done1, dir1;

    logic           en4, wr4, tick4;
    logic [c_W-1:0] duty4;
    logic           busy4, done4, dir4;

    int n_tests = 0;
    int n_fail  = 0;

    pwm_duty_ramp #(.WIDTH(c_W), .DIV(1)) u_div1 (
        .CLK(CLK), .RST(RST), .en(en1), .wr(wr1),
        .wr_target(wr_target), .wr_step(wr_step), .period(period),
        .tick(tick1), .duty(duty1), .busy(busy1), .done(done1), .dir(dir1)
    );

    pwm_duty_ramp #(.WIDTH(c_W), .DIV(4)) u_div4 (
        .CLK(CLK), .RST(RST), .en(en4), .wr(wr4),
        .wr_target(wr_target), .wr_step(wr_step), .period(period),
        .tick(tick4), .duty(duty4), .busy(busy4), .done(done4), .dir(dir4)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic           rst;
        logic           wr;
        logic [c_W-1:0] tgt;
        logic [c_W-1:0] stp;
        logic           tk;
        logic           en;
        logic [c_W-1:0] per;
        logic [c_W-1:0] e_duty;
        logic           e_busy;
        logic           e_done;
        logic           e_dir;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input logic rst, input logic wr,
                                input int tgt, input int stp,
                                input logic tk, input logic en, input int per,
                                input int e_duty, input logic e_busy,
                                input logic e_done, input logic e_dir);
        vec_t v;
        v.rst = rst; v.wr = wr; v.tgt = c_W'(tgt); v.stp = c_W'(stp);
        v.tk = tk; v.en = en; v.per = c_W'(per);
        v.e_duty = c_W'(e_duty); v.e_busy = e_busy;
        v.e_done = e_done; v.e_dir = e_dir;
        vecs.push_back(v);
    endfunction

    task automatic chk(input string nm, input logic [c_W-1:0] act,
                       input logic [c_W-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    // Advance one clock; outputs are sampled 1ns after the rising edge.
    task automatic cyc();
        @(posedge CLK);
        #1;
    endtask

    task automatic do4(input logic w, input int tgt, input int stp,
                       input logic tk, input logic e);
        wr4 = w; wr_target = c_W'(tgt); wr_step = c_W'(stp);
        tick4 = tk; en4 = e;
        cyc();
        wr4 = 1'b0; tick4 = 1'b0;
    endtask

    task automatic chk4(input string nm, input int e_duty, input logic e_busy,
                        input logic e_done, input logic e_dir);
        chk({nm, ".duty"}, duty4, c_W'(e_duty));
        chk({nm, ".busy"}, {27'd0, busy4}, {27'd0, e_busy});
        chk({nm, ".done"}, {27'd0, done4}, {27'd0, e_done});
        chk({nm, ".dir"},  {27'd0, dir4},  {27'd0, e_dir});
    endtask

    initial begin
        RST = 1'b1; wr_target = '0; wr_step = '0; period = c_W'(1000);
        en1 = 1'b1; wr1 = 1'b0; tick1 = 1'b0;
        en4 = 1'b1; wr4 = 1'b0; tick4 = 1'b0;

        // rst wr  tgt  stp tk en per   duty busy done dir
        // Ramp up, DIV=1
        add(0, 1, 100, 30, 0, 1, 1000,   0, 1, 0, 1);
        add(0, 0,   0,  0, 0, 1, 1000,   0, 1, 0, 1);
        add(0, 0,   0,  0, 1, 1, 1000,  30, 1, 0, 1);
        add(0, 0,   0,  0, 1, 1, 1000,  60, 1, 0, 1);
        add(0, 0,   0,  0, 1, 1, 1000,  90, 1, 0, 1);
        add(0, 0,   0,  0, 1, 1, 1000, 100, 0, 1, 0);
        add(0, 0,   0,  0, 0, 1, 1000, 100, 0, 0, 0);
        add(0, 0,   0,  0, 1, 1, 1000, 100, 0, 0, 0);
        // Zero step jump and no-op write
        add(0, 1, 700,  0, 0, 1, 1000, 100, 1, 0, 1);
        add(0, 0,   0,  0, 1, 1, 1000, 700, 0, 1, 0);
        add(0, 1, 700,  0, 0, 1, 1000, 700, 0, 1, 0);
        add(0, 0,   0,  0, 0, 1, 1000, 700, 0, 0, 0);
        // Period clamp with cur = 800
        add(0, 1, 800,  0, 0, 1, 1000, 700, 1, 0, 1);
        add(0, 0,   0,  0, 1, 1, 1000, 800, 0, 1, 0);
        add(0, 0,   0,  0, 0, 1,  500, 500, 0, 0, 0);
        add(0, 0,   0,  0, 0, 1, 1000, 800, 0, 0, 0);
        // Retarget colliding with a tick
        add(1, 0,   0,  0, 0, 1, 1000,   0, 0, 0, 0);
        add(0, 1, 100, 30, 0, 1, 1000,   0, 1, 0, 1);
        add(0, 0,   0,  0, 1, 1, 1000,  30, 1, 0, 1);
        add(0, 0,   0,  0, 1, 1, 1000,  60, 1, 0, 1);
        add(0, 1,   0, 25, 1, 1, 1000,  60, 1, 0, 0);
        add(0, 0,   0,  0, 1, 1, 1000,  35, 1, 0, 0);
        add(0, 0,   0,  0, 1, 1, 1000,  10, 1, 0, 0);
        add(0, 0,   0,  0, 1, 1, 1000,   0, 0, 1, 0);
        // Reset mid-ramp, then ticks ignored until a new write
        add(0, 1, 500,100, 0, 1, 1000,   0, 1, 0, 1);
        add(0, 0,   0,  0, 1, 1, 1000, 100, 1, 0, 1);
        add(1, 0,   0,  0, 1, 1, 1000,   0, 0, 0, 0);
        add(0, 0,   0,  0, 1, 1, 1000,   0, 0, 0, 0);
        add(0, 0,   0,  0, 1, 1, 1000,   0, 0, 0, 0);
        add(0, 1,  50,  0, 0, 1, 1000,   0, 1, 0, 1);
        add(0, 0,   0,  0, 1, 1, 1000,  50, 0, 1, 0);

        // Reset state of both instances
        cyc();
        cyc();
        chk("rst.duty1", duty1, '0);
        chk("rst.busy1", {27'd0, busy1}, '0);
        chk("rst.done1", {27'd0, done1}, '0);
        chk("rst.dir1",  {27'd0, dir1},  '0);
        chk4("rst4", 0, 1'b0, 1'b0, 1'b0);
        RST = 1'b0;

        foreach (vecs[i]) begin
            RST = vecs[i].rst; wr1 = vecs[i].wr;
            wr_target = vecs[i].tgt; wr_step = vecs[i].stp;
            tick1 = vecs[i].tk; en1 = vecs[i].en; period = vecs[i].per;
            cyc();
            RST = 1'b0; wr1 = 1'b0; tick1 = 1'b0;
            chk($sformatf("v%0d.duty", i), duty1, vecs[i].e_duty);
            chk($sformatf("v%0d.busy", i), {27'd0, busy1}, {27'd0, vecs[i].e_busy});
            chk($sformatf("v%0d.done", i), {27'd0, done1}, {27'd0, vecs[i].e_done});
            chk($sformatf("v%0d.dir", i),  {27'd0, dir1},  {27'd0, vecs[i].e_dir});
        end
        period = c_W'(1000);

        // DIV=4: bring cur to 100 with a zero-step jump (needs 4 ticks)
        do4(1'b1, 100, 0, 1'b0, 1'b1);
        chk4("j.wr", 0, 1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) begin
            do4(1'b0, 0, 0, 1'b1, 1'b1);
            chk4($sformatf("j.t%0d", i), (i == 3) ? 100 : 0,
                 (i != 3), (i == 3), (i != 3));
        end

        // DIV=4 ramp down 100 -> 20 by 50
        do4(1'b1, 20, 50, 1'b0, 1'b1);
        chk4("dn.wr", 100, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) begin
            do4(1'b0, 0, 0, 1'b1, 1'b1);
            chk4($sformatf("dn.t%0d", i), (i < 3) ? 100 : (i < 7) ? 50 : 20,
                 (i < 7), (i == 7), 1'b0);
        end

        // Enable freeze with prescale count preserved
        do4(1'b1, 100, 40, 1'b0, 1'b1);
        chk4("en.wr", 20, 1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 2; i++) begin
            do4(1'b0, 0, 0, 1'b1, 1'b1);
            chk4($sformatf("en.pre%0d", i), 20, 1'b1, 1'b0, 1'b1);
        end
        for (int i = 0; i < 10; i++) begin
            do4(1'b0, 0, 0, 1'b1, 1'b0);
            chk4($sformatf("en.off%0d", i), 20, 1'b1, 1'b0, 1'b1);
        end
        period = c_W'(10);
        do4(1'b0, 0, 0, 1'b0, 1'b0);
        chk4("en.clamp", 10, 1'b1, 1'b0, 1'b1);
        period = c_W'(1000);
        do4(1'b0, 0, 0, 1'b0, 1'b0);
        chk4("en.unclamp", 20, 1'b1, 1'b0, 1'b1);
        do4(1'b0, 0, 0, 1'b1, 1'b1);
        chk4("en.res0", 20, 1'b1, 1'b0, 1'b1);
        do4(1'b0, 0, 0, 1'b1, 1'b1);
        chk4("en.res1", 60, 1'b1, 1'b0, 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
